conv2d_kernel_engine: RTL and testbench

Parametrised 3x3 2-D convolution engine with a programmable kernel. It is the successor to the fixed conv2d block.
- Reads an IMG_W x IMG_H unsigned image from a zero-latency (combinational-read) frame memory.
- Computes each output pixel by sequential 9-tap multiply-accumulate, then rounds, shifts and saturates the result.
- Writes results to an output frame memory.
- Supports "valid" and "same" (zero-padded) border modes.

---
 rtl/conv2d_pkg.sv | 31 +++
 rtl/conv2d_mac.sv | 62 ++++++
 rtl/conv2d_kernel_engine.sv | 211 +++++++++++++++++++++
 tb/tb_conv2d_kernel_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared types and elaboration helpers for the 3x3 programmable convolution engine.
// Holds the FSM encoding, tap offsets, dimension/width helpers and the identity kernel.
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAP   = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int NUM_TAPS  = 9;
  localparam int IDENT_IDX = 4;

  // Row-major 3x3 window: tap = dy*3 + dx.
  localparam int TAP_DY [0:8] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  localparam int TAP_DX [0:8] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction

  function automatic int out_dim(input int img, input logic same);
    return same ? img : img - 2;
  endfunction

  function automatic int ident_coef(input int idx, input int shift);
    return (idx == IDENT_IDX) ? (1 << shift) : 0;
  endfunction

endpackage

// File: rtl/conv2d_mac.sv
// Multiply-accumulate datapath: unsigned pixel x signed coefficient into a guarded
// accumulator, plus round-half-up, arithmetic shift and clamp of the running sum.
module conv2d_mac
  import conv2d_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_pix,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic [DATA_W-1:0]        o_res
);

  localparam int ACC_W  = acc_width(DATA_W, COEF_W);
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << DATA_W) - 1);

  logic signed [PROD_W-1:0] w_pix_ext;
  logic signed [PROD_W-1:0] w_coef_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shr;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_pix_ext  = $signed({{(COEF_W + 1){1'b0}}, i_pix});
  assign w_coef_ext = $signed({{(DATA_W + 1){i_coef[COEF_W-1]}}, i_coef});
  assign w_prod     = w_pix_ext * w_coef_ext;

  // The sum including the current tap feeds the result so the last tap lands in d_out directly.
  assign w_sum = i_en ? (r_acc + {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod}) : r_acc;
  assign w_rnd = {w_sum[ACC_W-1], w_sum} + RND;
  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_res = '0;
    if (w_shr[ACC_W]) begin
      o_res = '0;
    end else if (w_shr > PIX_MAX) begin
      o_res = {DATA_W{1'b1}};
    end else begin
      o_res = w_shr[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/conv2d_kernel_engine.sv
// 3x3 programmable-kernel convolution engine: walks output pixels, issues nine reads per pixel
// (one tap per cycle), accumulates through conv2d_mac and writes one clamped result per pixel.
module conv2d_kernel_engine
  import conv2d_pkg::*;
#(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 12,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_same,
  input  logic [DATA_W-1:0] d_in,
  output logic [ADDR_W-1:0] addr_rd,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] d_out,
  output logic              wr_en,
  output logic              ready,
  output logic              done,
  input  logic              coef_we,
  input  logic [3:0]        coef_idx,
  input  logic [COEF_W-1:0] coef_data
);

  state_t                  r_state;
  logic [3:0]              r_tap;
  logic [ADDR_W-1:0]       r_orow;
  logic [ADDR_W-1:0]       r_ocol;
  logic [ADDR_W-1:0]       r_addr_rd;
  logic [ADDR_W-1:0]       r_addr_wr;
  logic [DATA_W-1:0]       r_d_out;
  logic                    r_same;
  logic                    r_tap_ok;
  logic                    r_wr_en;
  logic                    r_done;
  logic                    r_ready;
  logic signed [COEF_W-1:0] r_coef [0:NUM_TAPS-1];

  int                      w_out_w;
  int                      w_out_h;
  logic                    w_last_col;
  logic                    w_last_pix;
  logic [ADDR_W-1:0]       w_nxt_orow;
  logic [ADDR_W-1:0]       w_nxt_ocol;
  logic [ADDR_W-1:0]       w_n_row;
  logic [ADDR_W-1:0]       w_n_col;
  logic [3:0]              w_n_tap;
  logic                    w_n_same;
  int                      w_irow;
  int                      w_icol;
  logic                    w_n_ok;
  logic [ADDR_W-1:0]       w_n_addr;
  logic                    w_mac_clr;
  logic                    w_mac_en;
  logic signed [COEF_W-1:0] w_coef;
  logic [DATA_W-1:0]       w_mac_res;

  always_comb begin
    w_out_w    = out_dim(IMG_W, r_same);
    w_out_h    = out_dim(IMG_H, r_same);
    w_last_col = (int'(r_ocol) == w_out_w - 1);
    w_last_pix = w_last_col && (int'(r_orow) == w_out_h - 1);
    if (w_last_col) begin
      w_nxt_ocol = '0;
      w_nxt_orow = r_orow + ADDR_W'(1);
    end else begin
      w_nxt_ocol = r_ocol + ADDR_W'(1);
      w_nxt_orow = r_orow;
    end
  end

  // Read address is registered, so the position of the tap executed next cycle is computed here.
  always_comb begin
    w_n_row  = r_orow;
    w_n_col  = r_ocol;
    w_n_tap  = 4'd0;
    w_n_same = r_same;
    case (r_state)
      IDLE: begin
        w_n_row  = '0;
        w_n_col  = '0;
        w_n_same = mode_same;
      end
      TAP: begin
        w_n_tap = (r_tap < 4'd8) ? (r_tap + 4'd1) : 4'd0;
      end
      WRITE: begin
        w_n_row = w_nxt_orow;
        w_n_col = w_nxt_ocol;
      end
      default: begin
        w_n_tap = 4'd0;
      end
    endcase
    w_irow   = int'(w_n_row) + TAP_DY[w_n_tap] - int'(w_n_same);
    w_icol   = int'(w_n_col) + TAP_DX[w_n_tap] - int'(w_n_same);
    w_n_ok   = (w_irow >= 0) && (w_irow < IMG_H) && (w_icol >= 0) && (w_icol < IMG_W);
    w_n_addr = ADDR_W'(w_irow * IMG_W + w_icol);
  end

  assign w_mac_clr = ((r_state == IDLE) && start) || (r_state == WRITE);
  assign w_mac_en  = (r_state == TAP) && r_tap_ok;
  assign w_coef    = (r_tap <= 4'd8) ? r_coef[r_tap] : '0;

  conv2d_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_mac_clr),
    .i_en   (w_mac_en),
    .i_pix  (d_in),
    .i_coef (w_coef),
    .o_res  (w_mac_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tap     <= 4'd0;
      r_orow    <= '0;
      r_ocol    <= '0;
      r_addr_rd <= '0;
      r_addr_wr <= '0;
      r_d_out   <= '0;
      r_same    <= 1'b0;
      r_tap_ok  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_coef[i] <= COEF_W'(ident_coef(i, SHIFT));
      end
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (r_ready && coef_we && (coef_idx <= 4'd8)) begin
        r_coef[coef_idx] <= coef_data;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_same   <= mode_same;
            r_orow   <= '0;
            r_ocol   <= '0;
            r_tap    <= 4'd0;
            r_ready  <= 1'b0;
            r_state  <= TAP;
            r_tap_ok <= w_n_ok;
            if (w_n_ok) begin
              r_addr_rd <= w_n_addr;
            end
          end
        end
        TAP: begin
          if (r_tap == 4'd8) begin
            r_state   <= WRITE;
            r_wr_en   <= 1'b1;
            r_d_out   <= w_mac_res;
            r_addr_wr <= ADDR_W'(int'(r_orow) * w_out_w + int'(r_ocol));
          end else begin
            r_tap    <= r_tap + 4'd1;
            r_tap_ok <= w_n_ok;
            if (w_n_ok) begin
              r_addr_rd <= w_n_addr;
            end
          end
        end
        WRITE: begin
          r_ocol <= w_nxt_ocol;
          r_orow <= w_nxt_orow;
          if (w_last_pix) begin
            r_state <= HOLD;
            r_done  <= 1'b1;
          end else begin
            r_state  <= TAP;
            r_tap    <= 4'd0;
            r_tap_ok <= w_n_ok;
            if (w_n_ok) begin
              r_addr_rd <= w_n_addr;
            end
          end
        end
        HOLD: begin
          if (!start) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign addr_rd = r_addr_rd;
  assign addr_wr = r_addr_wr;
  assign d_out   = r_d_out;
  assign wr_en   = r_wr_en;
  assign ready   = r_ready;
  assign done    = r_done;

endmodule

// File: tb/tb_conv2d_kernel_engine.sv
// Scoreboard bench for conv2d_kernel_engine: a direct convolution model queues expected writes,
// which are popped and compared as the engine emits them. Instance 1 uses SHIFT=2 for rounding.
module tb_conv2d_kernel_engine;

  localparam int IW = 5;
  localparam int IH = 5;
  localparam int DW = 12;
  localparam int CW = 8;
  localparam int AW = 17;
  localparam int N  = IW * IH;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [2];
  logic          start     [2];
  logic          mode_same [2];
  logic          coef_we   [2];
  logic [3:0]    coef_idx  [2];
  logic [CW-1:0] coef_data [2];
  logic [DW-1:0] d_in      [2];
  logic [DW-1:0] d_out     [2];
  logic [AW-1:0] addr_rd   [2];
  logic [AW-1:0] addr_wr   [2];
  logic          wr_en     [2];
  logic          ready     [2];
  logic          done      [2];

  int   mem   [2][0:N-1];
  int   mcoef [2][0:8];
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;

  assign d_in[0] = (addr_rd[0] < AW'(N)) ? DW'(mem[0][addr_rd[0][4:0]]) : '0;
  assign d_in[1] = (addr_rd[1] < AW'(N)) ? DW'(mem[1][addr_rd[1][4:0]]) : '0;

  conv2d_kernel_engine #(
    .IMG_W(IW), .IMG_H(IH), .DATA_W(DW), .COEF_W(CW), .SHIFT(0), .ADDR_W(AW)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .mode_same(mode_same[0]), .d_in(d_in[0]),
    .addr_rd(addr_rd[0]), .addr_wr(addr_wr[0]), .d_out(d_out[0]), .wr_en(wr_en[0]),
    .ready(ready[0]), .done(done[0]), .coef_we(coef_we[0]), .coef_idx(coef_idx[0]),
    .coef_data(coef_data[0])
  );

  conv2d_kernel_engine #(
    .IMG_W(IW), .IMG_H(IH), .DATA_W(DW), .COEF_W(CW), .SHIFT(2), .ADDR_W(AW)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .mode_same(mode_same[1]), .d_in(d_in[1]),
    .addr_rd(addr_rd[1]), .addr_wr(addr_wr[1]), .d_out(d_out[1]), .wr_en(wr_en[1]),
    .ready(ready[1]), .done(done[1]), .coef_we(coef_we[1]), .coef_idx(coef_idx[1]),
    .coef_data(coef_data[1])
  );

  task automatic set_identity_model(input int s);
    for (int t = 0; t < 9; t++) mcoef[s][t] = (t == 4) ? ((s == 1) ? 4 : 1) : 0;
  endtask

  task automatic model_frame(input int s, input bit same);
    int ow, oh, off, sh, acc, r, rr, cc;
    exp_t e;
    ow  = same ? IW : IW - 2;
    oh  = same ? IH : IH - 2;
    off = same ? 1 : 0;
    sh  = (s == 1) ? 2 : 0;
    for (int orow = 0; orow < oh; orow++) begin
      for (int ocol = 0; ocol < ow; ocol++) begin
        acc = 0;
        for (int t = 0; t < 9; t++) begin
          rr = orow + t / 3 - off;
          cc = ocol + t % 3 - off;
          if (rr >= 0 && rr < IH && cc >= 0 && cc < IW) acc += mem[s][rr * IW + cc] * mcoef[s][t];
        end
        r = (acc + ((1 << sh) >> 1)) >>> sh;
        if (r < 0) r = 0;
        if (r > 4095) r = 4095;
        e.addr = orow * ow + ocol;
        e.data = r;
        q.push_back(e);
      end
    end
  endtask

  task automatic write_coef(input int s, input int idx, input int val);
    coef_we[s]   = 1'b1;
    coef_idx[s]  = 4'(idx);
    coef_data[s] = CW'(val);
    @(posedge clk); #1;
    coef_we[s] = 1'b0;
    if (idx <= 8) mcoef[s][idx] = val;
  endtask

  task automatic test_reset(input int s);
    rst[s] = 1'b1; start[s] = 1'b0; coef_we[s] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ready[s] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", s, ready[s]); end
    checks++; if (wr_en[s] !== 1'b0) begin errors++; $display("FAIL reset_wr_en[%0d]: got %b want 0", s, wr_en[s]); end
    checks++; if (done[s] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", s, done[s]); end
    checks++; if (addr_rd[s] !== '0) begin errors++; $display("FAIL reset_addr_rd[%0d]: got %0d want 0", s, addr_rd[s]); end
    checks++; if (addr_wr[s] !== '0) begin errors++; $display("FAIL reset_addr_wr[%0d]: got %0d want 0", s, addr_wr[s]); end
    checks++; if (d_out[s] !== '0) begin errors++; $display("FAIL reset_d_out[%0d]: got %0d want 0", s, d_out[s]); end
    rst[s] = 1'b0;
    set_identity_model(s);
    q.delete();
  endtask

  // Runs one frame with start held; optionally fires a busy-time coef write at cycle cwe_at.
  task automatic run_frame(input int s, input bit same, input int cwe_at, input string name);
    int c, first_wr, done_c, n_out;
    exp_t e;
    model_frame(s, same);
    n_out = q.size();
    mode_same[s] = same;
    start[s] = 1'b1;
    c = 0; first_wr = -1; done_c = -1;
    while (done_c < 0 && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (c == 5) mode_same[s] = ~same;
      coef_we[s] = (c == cwe_at); coef_idx[s] = 4'd4; coef_data[s] = '0;
      checks++;
      if (addr_rd[s] >= AW'(N)) begin errors++; $display("FAIL %s addr_rd_range: got %0d want <%0d at cycle %0d", name, addr_rd[s], N, c); end
      if (wr_en[s] === 1'b1) begin
        if (first_wr < 0) first_wr = c;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL %s extra_write: got addr %0d data %0d want no write", name, addr_wr[s], d_out[s]);
        end else begin
          e = q.pop_front();
          if (addr_wr[s] !== AW'(e.addr) || d_out[s] !== DW'(e.data)) begin
            errors++;
            $display("FAIL %s write: got addr %0d data %0d want addr %0d data %0d", name, addr_wr[s], d_out[s], e.addr, e.data);
          end
        end
      end
      if (done[s] === 1'b1) done_c = c;
    end
    coef_we[s] = 1'b0;
    checks++; if (first_wr != 10) begin errors++; $display("FAIL %s first_wr_cycle: got %0d want 10", name, first_wr); end
    checks++; if (done_c != n_out * 10 + 1) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, n_out * 10 + 1); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL %s missing_writes: got %0d left want 0", name, q.size()); end
    q.delete();
    @(posedge clk); #1;
    checks++; if (done[s] !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, done[s]); end
    checks++; if (ready[s] !== 1'b0) begin errors++; $display("FAIL %s ready_hold: got %b want 0", name, ready[s]); end
    start[s] = 1'b0;
    mode_same[s] = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready[s] !== 1'b1) begin errors++; $display("FAIL %s ready_return: got %b want 1", name, ready[s]); end
  endtask

  task automatic test_ramp_valid();
    for (int i = 0; i < N; i++) mem[0][i] = i;
    run_frame(0, 1'b0, 0, "ramp_valid");
  endtask

  task automatic test_same_const();
    for (int i = 0; i < N; i++) mem[0][i] = 100;
    for (int t = 0; t < 9; t++) write_coef(0, t, 1);
    run_frame(0, 1'b1, 0, "same_const");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++) mem[0][i] = 4095;
    run_frame(0, 1'b0, 0, "sat_high");
    for (int t = 0; t < 9; t++) write_coef(0, t, (t == 4) ? -1 : 0);
    run_frame(0, 1'b0, 0, "sat_low");
  endtask

  task automatic test_rounding();
    for (int i = 0; i < N; i++) mem[1][i] = i;
    write_coef(1, 4, 1);
    run_frame(1, 1'b0, 0, "round_shift2");
  endtask

  task automatic test_coef_busy();
    for (int i = 0; i < N; i++) mem[0][i] = i;
    for (int t = 0; t < 9; t++) write_coef(0, t, (t == 4) ? 1 : 0);
    run_frame(0, 1'b0, 15, "coef_busy");
    write_coef(0, 4, 0);
    write_coef(0, 9, 7);
    run_frame(0, 1'b0, 0, "coef_idle");
  endtask

  task automatic test_midframe_reset();
    int c, nw, bad;
    exp_t e;
    for (int i = 0; i < N; i++) mem[0][i] = i;
    model_frame(0, 1'b0);
    start[0] = 1'b1;
    nw = 0;
    for (c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (wr_en[0] === 1'b1) begin
        nw++;
        e = q.pop_front();
        checks++;
        if (addr_wr[0] !== AW'(e.addr) || d_out[0] !== DW'(e.data)) begin
          errors++; $display("FAIL midrst write: got addr %0d data %0d want addr %0d data %0d", addr_wr[0], d_out[0], e.addr, e.data);
        end
      end
    end
    rst[0] = 1'b1; start[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %b want 0", wr_en[0]); end
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready[0]); end
    checks++; if (nw != 3) begin errors++; $display("FAIL midrst_writes_before: got %0d want 3", nw); end
    rst[0] = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (wr_en[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", bad); end
    q.delete();
    set_identity_model(0);
    run_frame(0, 1'b0, 0, "after_reset");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; mode_same[k] = 1'b0;
      coef_we[k] = 1'b0; coef_idx[k] = 4'd0; coef_data[k] = '0;
      for (int i = 0; i < N; i++) mem[k][i] = 0;
    end
    test_reset(0);
    test_reset(1);
    test_ramp_valid();
    test_same_const();
    test_saturation();
    test_rounding();
    test_coef_busy();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
